// File: rtl/ram_reg_xfer_ctrl.sv
// Block-move sequencer between the RAM IP and the register file.
// Copies LEN words RAM->REG (dir=0) or REG->RAM (dir=1). While idle, the
// host's datapath control signals pass straight through to the outputs.
module ram_reg_xfer_ctrl #(
  parameter int unsigned RAM_AW     = 16,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              dir,
  input  logic [RAM_AW-1:0] src_base,
  input  logic [RAM_AW-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        host_choice,
  input  logic              host_ram_wen,
  input  logic [RAM_AW-1:0] host_ram_addr,
  input  logic [REG_AW-1:0] host_raddr1,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_waddr,
  output logic [1:0]        choice,
  output logic              ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [REG_AW-1:0] raddr1,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic              busy,
  output logic              done,
  output logic              host_stall
);

  localparam int unsigned DCW = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_dir;
  logic [RAM_AW-1:0] r_src;
  logic [RAM_AW-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_k;
  logic [DCW-1:0]    r_dcnt;

  // Pending regfile writes waiting for RAM read data (valid + target address)
  logic              r_vld [RAM_RD_LAT];
  logic [REG_AW-1:0] r_wa  [RAM_RD_LAT];

  logic [RAM_AW-1:0] w_src_ram;
  logic [RAM_AW-1:0] w_dst_ram;
  logic [REG_AW-1:0] w_src_reg;
  logic [REG_AW-1:0] w_dst_reg;
  logic              w_last_issue;
  logic              w_drain_end;
  logic              w_rd_issue;

  // Per-word addresses wrap naturally at the port widths
  assign w_src_ram    = r_src + RAM_AW'(r_k);
  assign w_dst_ram    = r_dst + RAM_AW'(r_k);
  assign w_src_reg    = r_src[REG_AW-1:0] + REG_AW'(r_k);
  assign w_dst_reg    = r_dst[REG_AW-1:0] + REG_AW'(r_k);
  assign w_last_issue = (r_k == (r_len - LEN_W'(1)));
  assign w_drain_end  = (r_dcnt == DCW'(RAM_RD_LAT - 1));
  assign w_rd_issue   = (r_state == S_ISSUE) && !r_dir;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transfer parameters captured on start; issue and drain counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dir  <= 1'b0;
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_k    <= '0;
      r_dcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir <= dir;
            r_src <= src_base;
            r_dst <= dst_base;
            r_len <= len;
            r_k   <= '0;
          end
        end
        S_ISSUE: begin
          r_k    <= r_k + LEN_W'(1);
          r_dcnt <= '0;
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DCW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Read-to-write shift pipe; reset discards anything still in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < RAM_RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_wa[i]  <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_issue;
      r_wa[0]  <= w_dst_reg;
      for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_wa[i]  <= r_wa[i-1];
      end
    end
  end

  // Next state and output decode; host pass-through unless a transfer is running
  always_comb begin
    w_state_nxt = r_state;
    choice      = host_choice;
    ram_wen     = host_ram_wen;
    ram_addr    = host_ram_addr;
    raddr1      = host_raddr1;
    we          = host_we;
    waddr       = host_waddr;
    busy        = 1'b0;
    done        = 1'b0;
    host_stall  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (w_last_issue) begin
          w_state_nxt = r_dir ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (r_state != S_IDLE) begin
      busy       = 1'b1;
      host_stall = host_ram_wen | host_we;
      choice     = r_dir ? 2'b00 : 2'b01;
      ram_wen    = (r_state == S_ISSUE) && r_dir;
      ram_addr   = r_dir ? w_dst_ram : w_src_ram;
      raddr1     = w_src_reg;
      we         = r_vld[RAM_RD_LAT-1] && !r_dir;
      waddr      = r_wa[RAM_RD_LAT-1];
      done       = (r_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_ram_reg_xfer_ctrl.sv
// Bench for ram_reg_xfer_ctrl: a table of directed transfers plus random
// transfers, checked against array-level expected memory contents and
// expected busy/done/write-pulse counts.
module tb_ram_reg_xfer_ctrl;

  localparam int RAM_AW = 16;
  localparam int REG_AW = 5;
  localparam int LEN_W  = 6;
  localparam int LAT    = 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              dir;
  logic [RAM_AW-1:0] src_base;
  logic [RAM_AW-1:0] dst_base;
  logic [LEN_W-1:0]  len;
  logic [1:0]        host_choice;
  logic              host_ram_wen;
  logic [RAM_AW-1:0] host_ram_addr;
  logic [REG_AW-1:0] host_raddr1;
  logic              host_we;
  logic [REG_AW-1:0] host_waddr;
  logic [1:0]        choice;
  logic              ram_wen;
  logic [RAM_AW-1:0] ram_addr;
  logic [REG_AW-1:0] raddr1;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic              busy;
  logic              done;
  logic              host_stall;

  ram_reg_xfer_ctrl #(
    .RAM_AW(RAM_AW), .REG_AW(REG_AW), .LEN_W(LEN_W), .RAM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .dir(dir),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .host_choice(host_choice), .host_ram_wen(host_ram_wen),
    .host_ram_addr(host_ram_addr), .host_raddr1(host_raddr1),
    .host_we(host_we), .host_waddr(host_waddr),
    .choice(choice), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .raddr1(raddr1), .we(we), .waddr(waddr),
    .busy(busy), .done(done), .host_stall(host_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] tb_ram  [65536];
  logic [15:0] exp_ram [65536];
  logic [15:0] tb_reg  [32];
  logic [15:0] exp_reg [32];
  logic [15:0] rd_q;

  typedef struct {
    logic        d;
    logic [15:0] s;
    logic [15:0] ds;
    logic [5:0]  l;
    int          restart_at;
    int          rst_at;
    int          e_busy;
    int          e_wen;
    int          e_we;
    int          e_done;
    int          e_done_at;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic init_mem();
    for (int a = 0; a < 65536; a++) tb_ram[a] = 16'(a);
    for (int i = 0; i < 32; i++) tb_reg[i] = 16'(2 * i);
  endtask

  // Expected memory image after nwords are copied, from the pre-transfer image
  task automatic build_expect(input logic d, input logic [15:0] s,
                              input logic [15:0] ds, input int nwords);
    for (int a = 0; a < 65536; a++) exp_ram[a] = tb_ram[a];
    for (int i = 0; i < 32; i++) exp_reg[i] = tb_reg[i];
    for (int k = 0; k < nwords; k++) begin
      if (!d) exp_reg[(int'(ds) + k) % 32] = tb_ram[(int'(s) + k) % 65536];
      else    exp_ram[(int'(ds) + k) % 65536] = tb_reg[(int'(s) + k) % 32];
    end
  endtask

  task automatic cmp_mem(input string tag);
    int nr;
    int nm;
    nr = 0;
    nm = 0;
    for (int i = 0; i < 32; i++) if (tb_reg[i] !== exp_reg[i]) nr++;
    for (int a = 0; a < 65536; a++) if (tb_ram[a] !== exp_ram[a]) nm++;
    chk({tag, " reg contents"}, nr, 0);
    chk({tag, " ram contents"}, nm, 0);
  endtask

  // Runs one transfer from a falling edge; the RAM/regfile datapath is modelled
  // from the DUT's sampled control outputs.
  task automatic run_xfer(input logic d, input logic [15:0] s, input logic [15:0] ds,
                          input logic [5:0] l, input int restart_at, input int rst_at,
                          input logic rnd_host,
                          output int n_busy, output int n_wen, output int n_we,
                          output int n_done, output int done_at, output int n_err);
    int exp_done_at;
    int exp_b;
    int nb;
    exp_done_at = (l == 0) ? 1 : (d ? int'(l) + 1 : int'(l) + LAT + 1);
    n_busy = 0; n_wen = 0; n_we = 0; n_done = 0; done_at = 0; n_err = 0;
    dir = d; src_base = s; dst_base = ds; len = l; start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= exp_done_at + 3; i++) begin
      exp_b = ((rst_at != 0 && i > rst_at) || i > exp_done_at) ? 0 : 1;
      if (int'(busy) != exp_b) n_err++;
      if (host_stall !== (exp_b[0] & (host_ram_wen | host_we))) n_err++;
      if (busy && !done) n_busy++;
      if (ram_wen) n_wen++;
      if (we) n_we++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = i;
      end
      if (ram_wen && choice == 2'b00) tb_ram[ram_addr] = tb_reg[raddr1];
      if (we && choice == 2'b01) tb_reg[waddr] = rd_q;
      rd_q = tb_ram[ram_addr];
      start  = (i == restart_at);
      resetn = !(i == rst_at);
      if (rnd_host) begin
        nb = ((rst_at != 0 && i + 1 > rst_at) || i + 1 > exp_done_at) ? 0 : 1;
        host_choice   = 2'($urandom);
        host_ram_addr = 16'($urandom);
        host_raddr1   = 5'($urandom);
        host_waddr    = 5'($urandom);
        host_ram_wen  = (nb != 0) ? 1'($urandom) : 1'b0;
        host_we       = (nb != 0) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; resetn = 1'b1; host_ram_wen = 1'b0; host_we = 1'b0;
  endtask

  function automatic vec_t mk(logic d, logic [15:0] s, logic [15:0] ds, logic [5:0] l,
                              int ra, int rr, int eb, int ewen, int ewe, int edn, int eat);
    vec_t v;
    v.d = d; v.s = s; v.ds = ds; v.l = l; v.restart_at = ra; v.rst_at = rr;
    v.e_busy = eb; v.e_wen = ewen; v.e_we = ewe; v.e_done = edn; v.e_done_at = eat;
    return v;
  endfunction

  initial begin
    int nbusy, nwen, nwe, ndone, dat, nerr;
    logic        rd;
    logic [15:0] rs, rds;
    logic [5:0]  rl;
    string       tag;

    // dir src dst len restart reset | busy wen we done done_at
    vecs[0] = mk(1'b0, 16'h0001, 16'h0000, 6'd8,  0, 0, 9,  0,  8,  1, 10);
    vecs[1] = mk(1'b1, 16'h0000, 16'h0100, 6'd32, 0, 0, 32, 32, 0,  1, 33);
    vecs[2] = mk(1'b0, 16'h0040, 16'd30,   6'd4,  0, 0, 5,  0,  4,  1, 6);
    vecs[3] = mk(1'b1, 16'h0005, 16'hFFFF, 6'd2,  0, 0, 2,  2,  0,  1, 3);
    vecs[4] = mk(1'b0, 16'h0010, 16'h0003, 6'd0,  0, 0, 0,  0,  0,  1, 1);
    vecs[5] = mk(1'b1, 16'h0010, 16'h0003, 6'd0,  0, 0, 0,  0,  0,  1, 1);
    vecs[6] = mk(1'b1, 16'h0003, 16'h0200, 6'd4,  2, 0, 4,  4,  0,  1, 5);
    vecs[7] = mk(1'b0, 16'h0001, 16'h0008, 6'd8,  0, 3, 3,  0,  2,  0, 0);
    vecs[8] = mk(1'b0, 16'hFFF0, 16'h0007, 6'd63, 0, 0, 64, 0,  63, 1, 65);

    resetn = 1'b0; start = 1'b0; dir = 1'b0; src_base = '0; dst_base = '0; len = '0;
    host_choice = 2'b11; host_ram_wen = 1'b0; host_ram_addr = 16'h1234;
    host_raddr1 = 5'd4; host_we = 1'b1; host_waddr = 5'd9; rd_q = '0;
    init_mem();

    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset we passthru", int'(we), 1);
    chk("reset waddr passthru", int'(waddr), 9);
    chk("reset choice passthru", int'(choice), 3);
    chk("reset stall", int'(host_stall), 0);
    resetn = 1'b1; host_we = 1'b0;
    @(negedge clk);
    chk("idle ram_addr passthru", int'(ram_addr), 16'h1234);
    chk("idle raddr1 passthru", int'(raddr1), 4);

    for (int v = 0; v < 9; v++) begin
      tag = $sformatf("vec%0d", v);
      init_mem();
      build_expect(vecs[v].d, vecs[v].s, vecs[v].ds,
                   vecs[v].d ? vecs[v].e_wen : vecs[v].e_we);
      run_xfer(vecs[v].d, vecs[v].s, vecs[v].ds, vecs[v].l, vecs[v].restart_at,
               vecs[v].rst_at, 1'b0, nbusy, nwen, nwe, ndone, dat, nerr);
      chk({tag, " busy cycles"}, nbusy, vecs[v].e_busy);
      chk({tag, " ram_wen pulses"}, nwen, vecs[v].e_wen);
      chk({tag, " we pulses"}, nwe, vecs[v].e_we);
      chk({tag, " done pulses"}, ndone, vecs[v].e_done);
      chk({tag, " done cycle"}, dat, vecs[v].e_done_at);
      chk({tag, " busy/stall trace errs"}, nerr, 0);
      cmp_mem(tag);
    end

    init_mem();
    for (int r = 0; r < 16; r++) begin
      tag = $sformatf("rnd%0d", r);
      rd  = 1'($urandom);
      rs  = 16'($urandom);
      rds = 16'($urandom);
      rl  = 6'($urandom_range(0, 63));
      build_expect(rd, rs, rds, int'(rl));
      run_xfer(rd, rs, rds, rl, 0, 0, 1'b1, nbusy, nwen, nwe, ndone, dat, nerr);
      chk({tag, " busy cycles"}, nbusy, (rl == 0) ? 0 : int'(rl) + (rd ? 0 : LAT));
      chk({tag, " ram_wen pulses"}, nwen, rd ? int'(rl) : 0);
      chk({tag, " we pulses"}, nwe, rd ? 0 : int'(rl));
      chk({tag, " done pulses"}, ndone, 1);
      chk({tag, " busy/stall trace errs"}, nerr, 0);
      cmp_mem(tag);
    end

    host_ram_wen = 1'b1; host_we = 1'b1; host_raddr1 = 5'd7; host_choice = 2'b10;
    @(negedge clk);
    chk("final idle ram_wen passthru", int'(ram_wen), 1);
    chk("final idle we passthru", int'(we), 1);
    chk("final idle raddr1 passthru", int'(raddr1), 7);
    chk("final idle choice passthru", int'(choice), 2);
    chk("final idle stall", int'(host_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
